// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID register, stall hold buffer and branch squash
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        brValid,
  input  logic        brCond,
  input  logic [31:0] brTarget,
  input  logic        freeze,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemRdata,
  output logic        ifIdValid,
  output logic [31:0] ifIdInstr,
  output logic [31:0] ifIdPc,
  output logic        misalignErr
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic        squash, squash_nx;
  logic [31:0] hold_buf, hold_buf_nx;
  logic        id_valid_nx;
  logic [31:0] id_instr_nx, id_pc_nx;
  logic        err_nx;
  logic        redirect;
  logic [31:0] target;

  assign redirect = brValid & brCond;
  assign target   = {brTarget[31:2], 2'b00};

  // The request is gated by rst_n so it stays low while reset is held but
  // rises in the very first cycle after release.
  assign imemReq  = (state == S_FETCH) & rst_n;
  assign imemAddr = pc;

  // State register and all pipeline state; reset overrides every input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      squash      <= 1'b0;
      hold_buf    <= 32'h0;
      ifIdValid   <= 1'b0;
      ifIdInstr   <= 32'h0;
      ifIdPc      <= 32'h0;
      misalignErr <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      squash      <= squash_nx;
      hold_buf    <= hold_buf_nx;
      ifIdValid   <= id_valid_nx;
      ifIdInstr   <= id_instr_nx;
      ifIdPc      <= id_pc_nx;
      misalignErr <= err_nx;
    end
  end

  // Next-state logic: a taken branch wins over responses and stalls.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    squash_nx   = squash;
    hold_buf_nx = hold_buf;
    id_valid_nx = ifIdValid;
    id_instr_nx = ifIdInstr;
    id_pc_nx    = ifIdPc;
    err_nx      = 1'b0;

    if (redirect) begin
      pc_nx       = target;
      id_valid_nx = 1'b0;
      err_nx      = |brTarget[1:0];
    end

    case (state)
      S_FETCH: begin
        state_nx = redirect ? S_FETCH : S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          if (imemValid) begin
            // The in-flight word is the one being discarded, so nothing is left to squash.
            state_nx  = S_FETCH;
            squash_nx = 1'b0;
          end else begin
            squash_nx = 1'b1;
          end
        end else if (imemValid) begin
          if (squash) begin
            squash_nx = 1'b0;
            state_nx  = S_FETCH;
          end else if (!freeze) begin
            id_valid_nx = 1'b1;
            id_instr_nx = imemRdata;
            id_pc_nx    = pc;
            pc_nx       = pc + STEP;
            state_nx    = S_FETCH;
          end else begin
            hold_buf_nx = imemRdata;
            state_nx    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_nx = S_FETCH;
        end else if (!freeze) begin
          id_valid_nx = 1'b1;
          id_instr_nx = hold_buf;
          id_pc_nx    = pc;
          pc_nx       = pc + STEP;
          state_nx    = S_FETCH;
        end
      end
      default: begin
        state_nx = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage with memory model and reference predictor
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n, brValid, brCond, freeze, imemValid;
  logic [31:0] brTarget, imemRdata;
  logic        imemReq, ifIdValid, misalignErr;
  logic [31:0] imemAddr, ifIdInstr, ifIdPc;

  int n_checks = 0;
  int n_fail   = 0;

  // memory responder
  logic        mem_busy = 1'b0;
  int          mem_cnt  = 0;
  int          mem_lat  = 1;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] req_log[$];

  // reference predictor: where the fetch unit is in its transaction
  logic        m_outstanding, m_held, m_squash, m_valid, m_err;
  logic [31:0] m_pc, m_instr, m_ifpc, m_hbuf;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .brValid(brValid), .brCond(brCond), .brTarget(brTarget),
    .freeze(freeze), .imemReq(imemReq), .imemAddr(imemAddr), .imemValid(imemValid),
    .imemRdata(imemRdata), .ifIdValid(ifIdValid), .ifIdInstr(ifIdInstr), .ifIdPc(ifIdPc),
    .misalignErr(misalignErr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic m_fetching();
    return !m_outstanding && !m_held;
  endfunction

  // Predict the effect of the current inputs at the coming edge.
  task automatic model_step();
    logic redir;
    logic [31:0] tgt;
    if (!rst_n) begin
      m_outstanding = 0; m_held = 0; m_squash = 0; m_valid = 0; m_err = 0;
      m_pc = 32'h0; m_instr = 32'h0; m_ifpc = 32'h0; m_hbuf = 32'h0;
      return;
    end
    redir = brValid && brCond;
    tgt   = brTarget - (brTarget % 4);
    m_err = redir && (brTarget % 4 != 0);
    if (redir) begin
      m_pc = tgt;
      m_valid = 0;
    end
    if (m_fetching()) begin
      if (!redir) m_outstanding = 1;
    end else if (m_outstanding) begin
      if (redir) begin
        if (imemValid) begin m_outstanding = 0; m_squash = 0; end
        else m_squash = 1;
      end else if (imemValid) begin
        m_outstanding = 0;
        if (m_squash) m_squash = 0;
        else if (!freeze) begin
          m_valid = 1; m_instr = imemRdata; m_ifpc = m_pc; m_pc = m_pc + 4;
        end else begin
          m_held = 1; m_hbuf = imemRdata;
        end
      end
    end else begin
      if (redir) m_held = 0;
      else if (!freeze) begin
        m_held = 0; m_valid = 1; m_instr = m_hbuf; m_ifpc = m_pc; m_pc = m_pc + 4;
      end
    end
  endtask

  // Apply one cycle of inputs, let memory answer, advance model and clock.
  task automatic cycle(input logic r, input logic bv, input logic bc, input logic [31:0] bt, input logic fz);
    rst_n = r; brValid = bv; brCond = bc; brTarget = bt; freeze = fz;
    imemValid = 1'b0; imemRdata = 32'h0;
    if (!r) mem_busy = 1'b0;
    else if (mem_busy) begin
      mem_cnt = mem_cnt - 1;
      if (mem_cnt == 0) begin
        imemValid = 1'b1; imemRdata = word_at(mem_addr); mem_busy = 1'b0;
      end
    end
    #1;
    if (imemReq === 1'b1) begin
      req_log.push_back(imemAddr);
      mem_busy = 1'b1; mem_cnt = mem_lat; mem_addr = imemAddr;
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h123, 1'b1);
    n_checks++; if (imemReq !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imemReq); end
    n_checks++; if (imemAddr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", imemAddr); end
    n_checks++; if (ifIdValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ifIdValid); end
    n_checks++; if (ifIdInstr !== 32'h0 || ifIdPc !== 32'h0) begin n_fail++; $display("FAIL reset_ifid: got %h/%h expected 0/0", ifIdInstr, ifIdPc); end
    n_checks++; if (misalignErr !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", misalignErr); end
  endtask

  task automatic test_sequential();
    logic [31:0] a1, a2;
    mem_lat = 1;
    req_log.delete();
    idle(1);
    n_checks++; if (req_log.size() != 1 || ifIdValid !== 1'b0) begin n_fail++; $display("FAIL seq_first_req: got reqs=%0d valid=%b expected 1/0", req_log.size(), ifIdValid); end
    cycle(1'b1, 1'b1, 1'b0, 32'h301, 1'b0);
    n_checks++; if (ifIdValid !== 1'b1 || ifIdPc !== 32'h0 || ifIdInstr !== word_at(32'h0)) begin n_fail++; $display("FAIL seq_load0: got v=%b pc=%h i=%h expected 1/0/%h", ifIdValid, ifIdPc, ifIdInstr, word_at(32'h0)); end
    n_checks++; if (misalignErr !== 1'b0) begin n_fail++; $display("FAIL seq_not_taken_err: got %b expected 0", misalignErr); end
    idle(2);
    n_checks++; if (ifIdPc !== 32'h4) begin n_fail++; $display("FAIL seq_load4: got %h expected 4", ifIdPc); end
    idle(2);
    n_checks++; if (ifIdPc !== 32'h8 || ifIdInstr !== word_at(32'h8)) begin n_fail++; $display("FAIL seq_load8: got %h/%h expected 8/%h", ifIdPc, ifIdInstr, word_at(32'h8)); end
    a1 = (req_log.size() > 1) ? req_log[1] : 32'hDEAD_BEEF;
    a2 = (req_log.size() > 2) ? req_log[2] : 32'hDEAD_BEEF;
    n_checks++; if (req_log.size() != 3 || a1 !== 32'h4 || a2 !== 32'h8) begin n_fail++; $display("FAIL seq_addrs: got n=%0d %h %h expected 3 4 8", req_log.size(), a1, a2); end
    n_checks++; if (imemReq !== 1'b1 || imemAddr !== 32'hC) begin n_fail++; $display("FAIL seq_next: got %b/%h expected 1/c", imemReq, imemAddr); end
  endtask

  task automatic test_freeze();
    mem_lat = 1;
    idle(1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++; if (ifIdPc !== 32'h8 || ifIdInstr !== word_at(32'h8) || ifIdValid !== 1'b1) begin n_fail++; $display("FAIL frz_hold: got %h/%h expected 8/%h", ifIdPc, ifIdInstr, word_at(32'h8)); end
    n_checks++; if (imemReq !== 1'b0) begin n_fail++; $display("FAIL frz_no_req: got %b expected 0", imemReq); end
    idle(1);
    n_checks++; if (ifIdPc !== 32'hC || ifIdInstr !== word_at(32'hC)) begin n_fail++; $display("FAIL frz_release: got %h/%h expected c/%h", ifIdPc, ifIdInstr, word_at(32'hC)); end
    n_checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h10) begin n_fail++; $display("FAIL frz_next: got %b/%h expected 1/10", imemReq, imemAddr); end
  endtask

  task automatic test_squash();
    mem_lat = 3;
    idle(1);
    cycle(1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
    n_checks++; if (ifIdValid !== 1'b0 || misalignErr !== 1'b0 || imemReq !== 1'b0) begin n_fail++; $display("FAIL sq_redirect: got v=%b e=%b r=%b expected 0/0/0", ifIdValid, misalignErr, imemReq); end
    idle(2);
    n_checks++; if (ifIdValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h100) begin n_fail++; $display("FAIL sq_drop: got v=%b r=%b a=%h expected 0/1/100", ifIdValid, imemReq, imemAddr); end
  endtask

  task automatic test_simultaneous();
    mem_lat = 2;
    idle(2);
    cycle(1'b1, 1'b1, 1'b1, 32'h40, 1'b1);
    n_checks++; if (ifIdValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 32'h40) begin n_fail++; $display("FAIL sim_redirect: got v=%b r=%b a=%h expected 0/1/40", ifIdValid, imemReq, imemAddr); end
    mem_lat = 1;
    idle(2);
    n_checks++; if (ifIdValid !== 1'b1 || ifIdPc !== 32'h40 || ifIdInstr !== word_at(32'h40)) begin n_fail++; $display("FAIL sim_no_squash: got v=%b pc=%h expected 1/40", ifIdValid, ifIdPc); end
  endtask

  task automatic test_misalign_wrap();
    mem_lat = 1;
    idle(1);
    cycle(1'b1, 1'b1, 1'b1, 32'h203, 1'b0);
    n_checks++; if (misalignErr !== 1'b1 || imemAddr !== 32'h200 || ifIdValid !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got e=%b a=%h v=%b expected 1/200/0", misalignErr, imemAddr, ifIdValid); end
    idle(1);
    n_checks++; if (misalignErr !== 1'b0) begin n_fail++; $display("FAIL mis_one_cycle: got %b expected 0", misalignErr); end
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    n_checks++; if (misalignErr !== 1'b0 || imemAddr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_target: got e=%b a=%h expected 0/fffffffc", misalignErr, imemAddr); end
    idle(2);
    n_checks++; if (ifIdPc !== 32'hFFFF_FFFC || imemReq !== 1'b1 || imemAddr !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got pc=%h r=%b a=%h expected fffffffc/1/0", ifIdPc, imemReq, imemAddr); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] a0;
    mem_lat = 1;
    idle(4);
    mem_lat = 3;
    idle(2);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (imemReq !== 1'b0 || imemAddr !== 32'h0 || misalignErr !== 1'b0) begin n_fail++; $display("FAIL mrst_imem: got r=%b a=%h e=%b expected 0/0/0", imemReq, imemAddr, misalignErr); end
    n_checks++; if (ifIdValid !== 1'b0 || ifIdInstr !== 32'h0 || ifIdPc !== 32'h0) begin n_fail++; $display("FAIL mrst_ifid: got %b/%h/%h expected 0/0/0", ifIdValid, ifIdInstr, ifIdPc); end
    req_log.delete();
    mem_lat = 1;
    idle(1);
    a0 = (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF;
    n_checks++; if (req_log.size() != 1 || a0 !== 32'h0) begin n_fail++; $display("FAIL mrst_first: got n=%0d a=%h expected 1/0", req_log.size(), a0); end
  endtask

  task automatic test_random();
    logic r, bv, bc, fz;
    logic [31:0] bt;
    for (int i = 0; i < 3000; i++) begin
      mem_lat = $urandom_range(3, 1);
      r  = ($urandom_range(99) != 0);
      fz = ($urandom_range(2) == 0);
      bv = !m_fetching() && ($urandom_range(4) == 0);
      bc = $urandom_range(1) == 1;
      bt = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : $urandom;
      cycle(r, bv, bc, bt, fz);
      n_checks++; if (imemReq !== (m_fetching() && rst_n)) begin n_fail++; $display("FAIL rnd_req @%0d: got %b expected %b", i, imemReq, m_fetching() && rst_n); end
      n_checks++; if (imemAddr !== m_pc) begin n_fail++; $display("FAIL rnd_addr @%0d: got %h expected %h", i, imemAddr, m_pc); end
      n_checks++; if (ifIdValid !== m_valid) begin n_fail++; $display("FAIL rnd_valid @%0d: got %b expected %b", i, ifIdValid, m_valid); end
      n_checks++; if (ifIdInstr !== m_instr) begin n_fail++; $display("FAIL rnd_instr @%0d: got %h expected %h", i, ifIdInstr, m_instr); end
      n_checks++; if (ifIdPc !== m_ifpc) begin n_fail++; $display("FAIL rnd_ifpc @%0d: got %h expected %h", i, ifIdPc, m_ifpc); end
      n_checks++; if (misalignErr !== m_err) begin n_fail++; $display("FAIL rnd_err @%0d: got %b expected %b", i, misalignErr, m_err); end
    end
  endtask

  initial begin
    rst_n = 1'b0; brValid = 1'b0; brCond = 1'b0; brTarget = 32'h0; freeze = 1'b0;
    imemValid = 1'b0; imemRdata = 32'h0;
    test_reset();
    test_sequential();
    test_freeze();
    test_squash();
    test_simultaneous();
    test_misalign_wrap();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset.
REQ-002 Parameter PC_STEP, default 4, is the sequential PC increment in bytes.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 brValid  input  1  EX stage holds a branch/jump this cycle.
REQ-006 brCond  input  1  branch-taken result from the condition checker; SHALL be ignored when brValid=0.
REQ-007 brTarget  input  32  redirect address, valid with brValid.
REQ-008 freeze  input  1  stall from the hazard unit; SHALL hold IF/ID contents.
REQ-009 imemReq  output  1  one-cycle instruction-fetch request pulse.
REQ-010 imemAddr  output  32  fetch address, valid while imemReq=1.
REQ-011 imemValid  input  1  one-cycle response pulse; at most one request outstanding; latency 1 or more cycles.
REQ-012 imemRdata  input  32  instruction word, valid with imemValid.
REQ-013 ifIdValid  output  1  IF/ID register holds a live instruction.
REQ-014 ifIdInstr  output  32  IF/ID instruction.
REQ-015 ifIdPc  output  32  PC of ifIdInstr.
REQ-016 misalignErr  output  1  one-cycle pulse: a taken target had nonzero bits [1:0].

Function
REQ-017 FSM states: FETCH, WAIT, HOLD; redirect = brValid and brCond.
REQ-018 FETCH: drive imemReq=1 and imemAddr=pc for exactly one cycle, then go to WAIT.
REQ-019 WAIT with imemValid=1, no redirect and freeze=0: load ifIdInstr=imemRdata, ifIdPc=pc and ifIdValid=1; set pc to pc+PC_STEP; go to FETCH.
REQ-020 WAIT with imemValid=1, no redirect and freeze=1: capture the word into a hold buffer and go to HOLD; IF/ID and pc stay unchanged.
REQ-021 HOLD: when freeze falls, load IF/ID from the hold buffer, advance pc by PC_STEP, and go to FETCH in the same cycle.
REQ-022 When freeze=1 and there is no redirect, ifIdValid, ifIdInstr and ifIdPc SHALL hold their values.
REQ-023 Redirect has priority over freeze and imemValid: in the next cycle pc={brTarget[31:2],2'b00} and ifIdValid=0.
REQ-024 Redirect in FETCH or HOLD: discard any held word and go to FETCH with the new pc; the next imemReq SHALL carry the target.
REQ-025 Redirect in WAIT without imemValid: set the squash flag and stay in WAIT.
REQ-026 When a response arrives with squash=1, discard it, clear squash, and go to FETCH.
REQ-027 Redirect in WAIT in the same cycle as imemValid: discard the response, leave squash clear, and go to FETCH.
REQ-028 A second redirect while squash=1 SHALL update pc only; squash stays 1.
REQ-029 brValid=1 with brCond=0 SHALL have no effect.
REQ-030 On a redirect with brTarget[1:0]!=0, pulse misalignErr for one cycle coinciding with the pc update.
REQ-031 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC plus 4 SHALL give 32'h0000_0000.
REQ-032 Latency from imemValid to ifIdValid SHALL be 1 cycle when unstalled; sequential fetch throughput is one instruction per (memory latency + 1) cycles.

Reset
REQ-033 With rst_n=0 at a clock edge: pc=RESET_PC, state=FETCH, squash=0, imemReq=0, imemAddr=RESET_PC, ifIdValid=0, ifIdInstr=0, ifIdPc=0, misalignErr=0.
REQ-034 Reset SHALL override all inputs, including an outstanding request; a late imemValid after reset without a matching request is a memory protocol error and is not handled.
REQ-035 The first imemReq SHALL occur in the first cycle after rst_n returns to 1.

Verification
REQ-036 Sequential fetch: reset release with 1-cycle memory -> imemAddr 0x0, 0x4, 0x8; ifIdPc follows 1 cycle after each imemValid.
REQ-037 Freeze in WAIT: imemValid with freeze=1 for 3 cycles -> IF/ID unchanged, FSM in HOLD; freeze falls -> IF/ID loads the held word, next imemAddr=pc+4.
REQ-038 Squash: redirect to 0x100 during a 3-cycle wait -> stale response dropped, ifIdValid=0, next imemAddr=0x100.
REQ-039 Simultaneous events: redirect to 0x40, imemValid and freeze=1 in one cycle -> ifIdValid=0, squash=0, next imemAddr=0x40.
REQ-040 Misalign and wrap: brTarget=0x203 -> pc=0x200 and one misalignErr pulse; pc=0xFFFF_FFFC fetch -> next imemAddr=0x0.
REQ-041 Mid-operation reset: rst_n=0 during WAIT -> all outputs at reset values next cycle; first imemAddr after release=RESET_PC.
